data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 53 +++++
 rtl/dmem_array.sv | 34 +++
 rtl/data_mem_resp.sv | 136 +++++++++++++
 tb/tb_data_mem_resp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared defines for the datapath: ALU opcodes, load/store access
// encodings, the data-memory response FSM states and a load-extension helper.
package data_mem_resp_pkg;

    // ALU operation select driven by the decoder
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Load/store width and extension, as carried in funct3
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Data-memory response FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Pick the addressed byte/half out of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_W:    load_extend = word;
            F3_BU:   load_extend = {24'h0, b};
            F3_HU:   load_extend = {16'h0, h};
            default: load_extend = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array with per-byte-lane write enables.
// Synchronous write, combinational read. Each word powers up holding its
// own index and is never touched by reset.
module dmem_array #(
    parameter int MEM_WORDS = 64,
    localparam int IDX_W    = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] words [MEM_WORDS];

    for (genvar i = 0; i < MEM_WORDS; i++) begin : g_word
        logic [31:0] word_q = 32'(i);

        // Write the enabled byte lanes of the addressed word
        always_ff @(posedge clk) begin
            for (int l = 0; l < 4; l++) begin
                if (be_i[l] && (idx_i == IDX_W'(i))) begin
                    word_q[8*l +: 8] <= wdata_i[8*l +: 8];
                end
            end
        end

        assign words[i] = word_q;
    end

    assign rdata_o = words[idx_i];

endmodule

// File: rtl/data_mem_resp.sv
// Load/store unit front end: accepts one request at a time, waits LATENCY
// cycles, then performs the access and pulses rvalid for one cycle.
// Alignment/legality checks and load extension live here; the array is
// a plain byte-lane-enabled memory.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int AW    = IDX_W + 2;

    dmem_state_e    state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [2:0]     f3_q, f3_d;
    logic [31:0]    wdata_q, wdata_d;

    logic           illegal, misaligned, bad;
    logic [3:0]     lane_be, mem_be;
    logic [31:0]    lane_data, mem_rdata;

    // Address bits above the array wrap and are deliberately dropped
    logic           unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW];

    // State and latched request; reset aborts any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state: accept in IDLE, count down in WAIT, one-cycle RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        ready   = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    we_d    = we;
                    addr_d  = addr[AW-1:0];
                    f3_d    = funct3;
                    wdata_d = wdata;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                rvalid  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Legality, alignment and byte-lane steering of the latched access
    always_comb begin
        illegal    = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111) ||
                     (we_q && ((f3_q == F3_BU) || (f3_q == F3_HU)));
        misaligned = (((f3_q == F3_H) || (f3_q == F3_HU)) && addr_q[0]) ||
                     ((f3_q == F3_W) && (addr_q[1:0] != 2'b00));
        bad        = illegal || misaligned;
        lane_be    = 4'b0000;
        lane_data  = 32'd0;
        case (f3_q)
            F3_B: begin
                lane_be   = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                lane_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            F3_W: begin
                lane_be   = 4'b1111;
                lane_data = wdata_q;
            end
            default: ;
        endcase
        // Stores commit only in the RESP cycle and only when legal
        mem_be = (rvalid && we_q && !bad) ? lane_be : 4'b0000;
        err    = rvalid && bad;
        rdata  = (rvalid && !we_q && !bad) ?
                 load_extend(mem_rdata, addr_q[1:0], f3_q) : 32'd0;
    end

    dmem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_array (
        .clk     (clk),
        .be_i    (mem_be),
        .idx_i   (addr_q[AW-1:2]),
        .wdata_i (lane_data),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomised scoreboard bench for data_mem_resp. The reference model is a
// byte-addressed memory; expected responses are queued at issue time and a
// negedge monitor checks every rvalid pulse (data, err and latency).
module tb_data_mem_resp;

    localparam int MW  = 64;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;

    data_mem_resp #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .funct3(funct3), .wdata(wdata), .ready(ready), .rvalid(rvalid),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       tag;
    } exp_t;
    exp_t q[$];

    logic [7:0] bm [MW*4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference: legality, alignment, store, extended load
    task automatic model(input logic w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int sz = 1;
        bit sgn = 0;
        int base;
        logic [31:0] v;
        rd = 32'd0;
        e  = 1'b0;
        case (f)
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: begin sz = 4; sgn = 0; end
            3'd4: begin sz = 1; sgn = 0; end
            3'd5: begin sz = 2; sgn = 0; end
            default: e = 1'b1;
        endcase
        if (w && f >= 3'd4) e = 1'b1;
        if (!e && (a % sz) != 0) e = 1'b1;
        if (e) return;
        base = int'(a % (MW*4));
        if (w) begin
            for (int k = 0; k < sz; k++) bm[base+k] = wd[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < sz; k++) v[8*k +: 8] = bm[base+k];
            if (sgn && v[8*sz-1]) for (int k = 8*sz; k < 32; k++) v[k] = 1'b1;
            rd = v;
        end
    endtask

    // Present a request (called at a negedge), wait for acceptance, queue
    // the expected response, then scramble the inputs so later changes
    // cannot leak into the in-flight access.
    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] wd, input bit hold, input string tag,
                         output int acc, output int waited);
        exp_t x;
        logic [31:0] rd;
        logic e;
        req = 1'b1; we = w; addr = a; funct3 = f; wdata = wd;
        waited = 0;
        acc = -1;
        while (!ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: not accepted within 50 cycles", tag);
            req = 1'b0;
            return;
        end
        acc = cyc;
        model(w, a, f, wd, rd, e);
        x = '{rd, e, cyc + LAT + 1, tag};
        q.push_back(x);
        @(negedge clk);
        if (!hold) req = 1'b0;
        we = 1'($urandom_range(0, 1)); addr = $urandom;
        funct3 = 3'($urandom_range(0, 7)); wdata = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d responses never arrived", q.size());
            q.delete();
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rvalid) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk({x.tag, ".rdata"}, rdata, x.rdata);
                chk({x.tag, ".err"}, 32'(err), 32'(x.err));
                chk({x.tag, ".latency"}, 32'(cyc), 32'(x.due));
            end
        end
    end

    initial begin
        int acc, waited, prev;
        for (int i = 0; i < MW; i++) begin
            logic [31:0] w;
            w = 32'(i);
            for (int k = 0; k < 4; k++) bm[4*i+k] = w[8*k +: 8];
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.rvalid", 32'(rvalid), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        reset = 1'b0;

        // Directed word/byte/half stores, extensions, errors, wrap
        issue(1, 32'h10, 3'd2, 32'hDEADBEEF, 0, "sw_10", acc, waited);
        issue(0, 32'h10, 3'd2, 32'h0, 0, "lw_10", acc, waited);
        issue(1, 32'h21, 3'd0, 32'h000000F0, 0, "sb_21", acc, waited);
        issue(0, 32'h20, 3'd2, 32'h0, 0, "lw_20", acc, waited);
        issue(0, 32'h21, 3'd0, 32'h0, 0, "lb_21", acc, waited);
        issue(0, 32'h21, 3'd4, 32'h0, 0, "lbu_21", acc, waited);
        issue(1, 32'h32, 3'd1, 32'h00008001, 0, "sh_32", acc, waited);
        issue(0, 32'h30, 3'd2, 32'h0, 0, "lw_30", acc, waited);
        issue(0, 32'h32, 3'd1, 32'h0, 0, "lh_32", acc, waited);
        issue(0, 32'h32, 3'd5, 32'h0, 0, "lhu_32", acc, waited);
        issue(1, 32'h13, 3'd2, 32'h11223344, 0, "sw_13_misal", acc, waited);
        issue(0, 32'h10, 3'd2, 32'h0, 0, "lw_10_again", acc, waited);
        issue(0, 32'h05, 3'd1, 32'h0, 0, "lh_05_misal", acc, waited);
        issue(1, 32'h08, 3'd4, 32'hFFFFFFFF, 0, "sbu_illegal", acc, waited);
        issue(0, 32'h08, 3'd3, 32'h0, 0, "ld_f3_011", acc, waited);
        issue(0, 32'h100, 3'd2, 32'h0, 0, "lw_100_wrap", acc, waited);
        drain();

        // Reset during WAIT aborts the store; next request accepted at once
        req = 1'b1; we = 1'b1; addr = 32'h40; funct3 = 3'd2; wdata = 32'h12345678;
        waited = 0;
        while (!ready && waited < 50) begin @(negedge clk); waited++; end
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(0, 32'h40, 3'd2, 32'h0, 0, "lw_40_after_abort", acc, waited);
        chk("abort.first_edge_accept", 32'(waited), 32'd0);
        drain();

        // Held req: one acceptance every LAT+2 cycles
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            issue(0, 32'(4*i), 3'd2, 32'h0, 1, "burst", acc, waited);
            if (prev >= 0) chk("burst.spacing", 32'(acc - prev), 32'(LAT + 2));
            prev = acc;
        end
        req = 1'b0;
        drain();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            logic w;
            logic [31:0] a;
            logic [2:0] f;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MW*4 - 1));
            issue(w, a, f, $urandom, bit'($urandom_range(0, 1)), "rand", acc, waited);
            if (!req) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
